// File: rtl/instruction_loader.sv
// Assembles UART bytes (MSB first) into instruction words and writes them to
// consecutive instruction-memory addresses until a HALT word or memory full.
module instruction_loader #(
    parameter int             NB         = 32,
    parameter int             DATA_BITS  = 8,
    parameter int             ADDR_BITS  = 8,
    parameter int             IMEM_DEPTH = 256,
    parameter logic [NB-1:0]  HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_uart_rx_ready,
    input  logic [DATA_BITS-1:0]  i_uart_rx_data,
    output logic                  o_imem_wr_en,
    output logic [ADDR_BITS-1:0]  o_imem_addr,
    output logic [NB-1:0]         o_imem_data,
    output logic                  o_load_done,
    output logic                  o_overflow,
    output logic [ADDR_BITS:0]    o_word_count
);

    localparam int BPW = NB / DATA_BITS;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(IMEM_DEPTH);
    localparam logic [BCW-1:0]     LAST_BYTE = BCW'(BPW - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [NB-1:0]          word_reg;
    logic [BCW-1:0]         byte_cnt_reg;
    logic [ADDR_BITS-1:0]   addr_reg;
    logic                   wr_en_reg;
    logic [ADDR_BITS-1:0]   imem_addr_reg;
    logic [NB-1:0]          imem_data_reg;
    logic                   done_reg;
    logic                   overflow_reg;
    logic [ADDR_BITS:0]     count_reg;

    logic [NB-1:0]          word_next;
    logic [ADDR_BITS:0]     count_next;
    logic [BPW-1:0]         halt_lane;
    logic                   is_halt;

    assign word_next  = {word_reg[NB-DATA_BITS-1:0], i_uart_rx_data};
    assign count_next = count_reg + 1'b1;

    // HALT detection compared lane by lane on the fully assembled word.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_halt_lane
            assign halt_lane[gi] =
                (word_reg[gi*DATA_BITS +: DATA_BITS] == HALT_WORD[gi*DATA_BITS +: DATA_BITS]);
        end
    endgenerate
    assign is_halt = &halt_lane;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            word_reg      <= '0;
            byte_cnt_reg  <= '0;
            addr_reg      <= '0;
            wr_en_reg     <= 1'b0;
            imem_addr_reg <= '0;
            imem_data_reg <= '0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            count_reg     <= '0;
        end else begin
            wr_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_enable) begin
                        state_reg    <= RECEIVE;
                        byte_cnt_reg <= '0;
                        addr_reg     <= '0;
                        count_reg    <= '0;
                    end
                end
                RECEIVE: begin
                    if (!i_enable) begin
                        state_reg <= IDLE;
                    end else if (i_uart_rx_ready) begin
                        word_reg <= word_next;
                        if (byte_cnt_reg == LAST_BYTE) begin
                            // Strobe is registered here so it is high during the WRITE cycle.
                            byte_cnt_reg  <= '0;
                            state_reg     <= WRITE;
                            wr_en_reg     <= 1'b1;
                            imem_addr_reg <= addr_reg;
                            imem_data_reg <= word_next;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    addr_reg  <= addr_reg + 1'b1;
                    count_reg <= count_next;
                    if (!i_enable) begin
                        state_reg <= IDLE;
                    end else if (is_halt) begin
                        state_reg    <= DONE;
                        done_reg     <= 1'b1;
                        overflow_reg <= 1'b0;
                    end else if (count_next == DEPTH_CNT) begin
                        state_reg    <= DONE;
                        done_reg     <= 1'b1;
                        overflow_reg <= 1'b1;
                    end else begin
                        // A byte arriving during WRITE starts the next word.
                        state_reg <= RECEIVE;
                        if (i_uart_rx_ready) begin
                            word_reg     <= word_next;
                            byte_cnt_reg <= BCW'(1);
                        end
                    end
                end
                DONE: begin
                    if (!i_enable) begin
                        state_reg    <= IDLE;
                        done_reg     <= 1'b0;
                        overflow_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_imem_wr_en = wr_en_reg;
    assign o_imem_addr  = imem_addr_reg;
    assign o_imem_data  = imem_data_reg;
    assign o_load_done  = done_reg;
    assign o_overflow   = overflow_reg;
    assign o_word_count = count_reg;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Byte-to-word instruction loader between the UART receiver and the MIPS pipeline's instruction memory. While the debug unit holds it enabled, it assembles received bytes into 32-bit instruction words, MSB first, and writes each word to consecutive instruction-memory word addresses starting at 0. Loading ends on a HALT word or on memory overflow, and the loader then raises a done flag for the debug unit.

## Interface
Parameters:
- `NB`, 32, instruction word width.
- `DATA_BITS`, 8, UART byte width; `NB` is a multiple of `DATA_BITS`; bytes per word `BPW = NB/DATA_BITS` (4).
- `ADDR_BITS`, 8, instruction-memory word-address width.
- `IMEM_DEPTH`, 256, number of writable words; must be ≤ 2^`ADDR_BITS`.
- `HALT_WORD`, 32'hFFFFFFFF, terminating instruction.

Ports:
- `i_clk`, input, 1, the only clock; all state updates on its rising edge.
- `i_reset`, input, 1, synchronous, active-high reset.
- `i_enable`, input, 1, level from the debug unit; high while in program-load mode.
- `i_uart_rx_ready`, input, 1, one-cycle pulse when a received byte is valid.
- `i_uart_rx_data`, input, `DATA_BITS`, received byte; sampled only when `i_uart_rx_ready`=1.
- `o_imem_wr_en`, output, 1, one-cycle write strobe to instruction memory.
- `o_imem_addr`, output, `ADDR_BITS`, word address for the write.
- `o_imem_data`, output, `NB`, assembled instruction.
- `o_load_done`, output, 1, level; high while in DONE.
- `o_overflow`, output, 1, level; high in DONE when it was entered by overflow.
- `o_word_count`, output, `ADDR_BITS+1`, number of words written in the current load.

## Operation
- Reset value of every output is 0. Reset also sets the state to IDLE and clears all internal registers: assembly shift register, byte counter and address counter.
- **IDLE**
  - `i_enable`=1 → RECEIVE; byte counter, address counter and `o_word_count` are cleared to 0.
  - Rx pulses are ignored in IDLE.
- **RECEIVE**
  - On each rx pulse: `word <= {word[NB-DATA_BITS-1:0], rx_data}` and the byte counter increments.
  - When the pulse delivers byte `BPW` (counter = `BPW-1`): the next state is WRITE and the byte counter resets to 0.
- **WRITE** (exactly one cycle)
  - `o_imem_wr_en`=1, `o_imem_addr`=address counter, `o_imem_data`=assembled word.
  - The address counter and `o_word_count` increment.
  - Word == `HALT_WORD` → DONE with `o_overflow`=0. The HALT word is written to memory.
  - Otherwise, if the incremented count == `IMEM_DEPTH` → DONE with `o_overflow`=1.
  - Otherwise → RECEIVE.
  - An rx pulse arriving in the WRITE cycle is accepted as byte 0 of the next word; no byte is lost. It is discarded if the next state is DONE.
- **DONE**
  - `o_load_done`=1. `o_overflow` and `o_word_count` are held.
  - Rx pulses are ignored; no writes occur.
- `i_enable`=0 in RECEIVE, WRITE or DONE → IDLE next cycle.
  - A partial word is discarded.
  - `o_load_done` and `o_overflow` clear.
  - `o_word_count` holds until the next load starts.
  - If `i_enable` falls during the WRITE cycle, that write still occurs.
- `o_imem_addr` and `o_imem_data` hold their last written values outside WRITE. Only `o_imem_wr_en` qualifies them.
- Reset asserted mid-load takes priority over all other conditions. The memory keeps the words already written.

## Timing
- Outputs are registered; there is no combinational path from inputs to outputs.
- Enable to ready: `i_enable` rising at cycle t → RECEIVE at t+1. The first byte is accepted from cycle t+1 onward.
- Write latency: the final byte's rx pulse at cycle n → `o_imem_wr_en` high during cycle n+1 only.
- Done latency: `o_load_done` rises at n+2 after the final byte of the HALT or overflow word.
- Back-to-back rx pulses on consecutive cycles are fully supported at one byte per cycle. The WRITE cycle does not stall reception.
- Disable latency: `i_enable` falling at cycle t → IDLE and flags cleared at t+1.

## Test plan
- **Normal load.** Enable, then send bytes 20 08 00 05 | 00 00 00 00 | FF FF FF FF.
  - Writes 0x20080005@0, 0x00000000@1, 0xFFFFFFFF@2.
  - Then `o_load_done`=1, `o_overflow`=0, `o_word_count`=3.
- **Write latency.** Send 4 bytes on 4 consecutive cycles starting at cycle 10.
  - `o_imem_wr_en` high exactly at cycle 14.
  - A 5th pulse at cycle 14 becomes the MSB of word 1.
- **Overflow.** With `IMEM_DEPTH`=4, send 4 non-HALT words.
  - 4 writes at addresses 0..3, then DONE with `o_overflow`=1 and `o_word_count`=4.
  - Further bytes produce no writes.
- **Abort.** Send 2 bytes, then drop `i_enable` for 1 cycle, then re-enable and send AA BB CC DD.
  - Write 0xAABBCCDD@0; the partial word is discarded.
- **Reset and idle.** With `i_enable`=0, rx pulses cause no writes.
  - Synchronous reset asserted mid-word → all outputs 0 the next cycle.
  - A re-enabled load restarts at address 0.
